// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and width helper for uart_fifo
// Contents:
//   uart_state_t  TX/RX frame states (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP)
//   clog2         ceil(log2(value)), used for pointer and counter widths
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
// Ports:
//   clk, reset   clock, synchronous active-high reset (empties the FIFO)
//   wr, din      push; accepted when not full, or when full with an accepted pop
//   rd           pop head; ignored while empty
//   dout         head entry (valid while !empty)
//   full, empty  level flags
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_rd;
   logic             do_wr;

   // Pointers carry one extra MSB so equal indices can mean full or empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_rd = rd && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_wr = wr && (!full || do_rd);
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - buffered UART with configurable frame and TX/RX FIFOs
// Optional feature: define UART_PARITY_EN to add an even parity bit after the data.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   uart_rxd / uart_txd     serial in (asynchronous) / serial out (idles high)
//   tx_data, tx_wr          push a byte into the TX FIFO
//   tx_full, tx_busy        TX FIFO full / TX FIFO non-empty or frame in flight
//   rx_data, rx_error       head of RX FIFO and its framing/parity flag
//   rx_avail, rx_ack        RX FIFO non-empty / pop head
//   rx_overrun              sticky: a received byte was lost to a full RX FIFO
module uart_fifo
   import uart_pkg::*;
#(
   parameter int FREQ_HZ    = 100000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_rxd,
   output logic                 uart_txd,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_error,
   output logic                 rx_avail,
   input  logic                 rx_ack,
   output logic                 rx_overrun
);

   localparam int DIV  = (FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int DIVW = clog2(DIV + 1);
   localparam int TW   = clog2(OVERSAMPLE + 1);
   localparam int BW   = clog2(DATA_BITS + 1);

   localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(DIV - 1);
   localparam logic [TW-1:0]   OS_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0]   HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic            STOP_LAST = (STOP_BITS == 2);

   // ---------------- baud tick ----------------
   logic [DIVW-1:0] baud_cnt;
   logic            tick;

   assign tick = (baud_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset || tick) baud_cnt <= '0;
      else               baud_cnt <= baud_cnt + 1'b1;
   end

   // ---------------- TX path ----------------
   logic [DATA_BITS-1:0] tx_head;
   logic                 tx_empty;
   logic                 tx_pop;
   uart_state_t          tx_state, tx_state_nxt;
   logic [TW-1:0]        tx_cnt, tx_cnt_nxt;
   logic [BW-1:0]        tx_idx, tx_idx_nxt;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
   logic                 tx_stop, tx_stop_nxt;
   logic                 txd_nxt;
   logic                 tx_bit_end;
`ifdef UART_PARITY_EN
   logic                 tx_par, tx_par_nxt;
`endif

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .din   (tx_data),
      .rd    (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign tx_busy    = !tx_empty || (tx_state != ST_IDLE);
   assign tx_bit_end = tick && (tx_cnt == OS_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= ST_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_stop  <= 1'b0;
         uart_txd <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_idx   <= tx_idx_nxt;
         tx_shift <= tx_shift_nxt;
         tx_stop  <= tx_stop_nxt;
         uart_txd <= txd_nxt;
`ifdef UART_PARITY_EN
         tx_par   <= tx_par_nxt;
`endif
      end
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_idx_nxt   = tx_idx;
      tx_shift_nxt = tx_shift;
      tx_stop_nxt  = tx_stop;
      tx_pop       = 1'b0;
      txd_nxt      = 1'b1;
`ifdef UART_PARITY_EN
      tx_par_nxt   = tx_par;
`endif
      if (tick && tx_state != ST_IDLE) begin
         tx_cnt_nxt = tx_bit_end ? '0 : tx_cnt + 1'b1;
      end
      case (tx_state)
         ST_IDLE: begin
            if (tick && !tx_empty) begin
               tx_pop       = 1'b1;
               tx_shift_nxt = tx_head;
               tx_cnt_nxt   = '0;
               tx_state_nxt = ST_START;
`ifdef UART_PARITY_EN
               tx_par_nxt   = ^tx_head;
`endif
            end
         end
         ST_START: begin
            if (tx_bit_end) begin
               tx_idx_nxt   = '0;
               tx_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_bit_end) begin
               tx_shift_nxt = tx_shift >> 1;
               if (tx_idx == DATA_LAST) begin
                  tx_stop_nxt = 1'b0;
`ifdef UART_PARITY_EN
                  tx_state_nxt = ST_PARITY;
`else
                  tx_state_nxt = ST_STOP;
`endif
               end else begin
                  tx_idx_nxt = tx_idx + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (tx_bit_end) begin
               tx_stop_nxt  = 1'b0;
               tx_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tx_bit_end) begin
               if (tx_stop == STOP_LAST) begin
                  // Chain straight into the next start bit so bursts have no idle gap.
                  if (!tx_empty) begin
                     tx_pop       = 1'b1;
                     tx_shift_nxt = tx_head;
                     tx_state_nxt = ST_START;
`ifdef UART_PARITY_EN
                     tx_par_nxt   = ^tx_head;
`endif
                  end else begin
                     tx_state_nxt = ST_IDLE;
                  end
               end else begin
                  tx_stop_nxt = 1'b1;
               end
            end
         end
         default: tx_state_nxt = ST_IDLE;
      endcase
      // Line level is registered from the next state so uart_txd is glitch-free.
      case (tx_state_nxt)
         ST_START:  txd_nxt = 1'b0;
         ST_DATA:   txd_nxt = tx_shift_nxt[0];
`ifdef UART_PARITY_EN
         ST_PARITY: txd_nxt = tx_par_nxt;
`endif
         default:   txd_nxt = 1'b1;
      endcase
   end

   // ---------------- RX path ----------------
   logic                 rx_s1, rx_s2, rx_prev;
   uart_state_t          rx_state, rx_state_nxt;
   logic [TW-1:0]        rx_cnt, rx_cnt_nxt;
   logic [BW-1:0]        rx_idx, rx_idx_nxt;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
   logic                 rx_push;
   logic                 rx_push_err;
   logic                 rx_mid;
   logic                 rx_mid_start;
   logic [DATA_BITS:0]   rx_head;
   logic                 rx_empty;
   logic                 rx_fifo_full;
   logic                 rx_pop;
`ifdef UART_PARITY_EN
   logic                 rx_par_err, rx_par_err_nxt;
`endif

   sync_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (rx_push),
      .din   ({rx_push_err, rx_shift}),
      .rd    (rx_pop),
      .dout  (rx_head),
      .full  (rx_fifo_full),
      .empty (rx_empty)
   );

   assign rx_avail     = !rx_empty;
   assign rx_pop       = rx_ack && rx_avail;
   // Head is forced to zero while empty so the never-written RAM is not exposed.
   assign rx_data      = rx_avail ? rx_head[DATA_BITS-1:0] : '0;
   assign rx_error     = rx_avail && rx_head[DATA_BITS];
   assign rx_mid       = tick && (rx_cnt == OS_LAST);
   assign rx_mid_start = tick && (rx_cnt == HALF_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= ST_IDLE;
         rx_cnt     <= '0;
         rx_idx     <= '0;
         rx_shift   <= '0;
         rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_err <= 1'b0;
`endif
      end else begin
         rx_s1    <= uart_rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_idx   <= rx_idx_nxt;
         rx_shift <= rx_shift_nxt;
`ifdef UART_PARITY_EN
         rx_par_err <= rx_par_err_nxt;
`endif
         // A fresh loss wins over an acknowledge in the same cycle.
         if (rx_push && rx_fifo_full && !rx_pop) rx_overrun <= 1'b1;
         else if (rx_pop)                         rx_overrun <= 1'b0;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_idx_nxt   = rx_idx;
      rx_shift_nxt = rx_shift;
      rx_push      = 1'b0;
      rx_push_err  = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err_nxt = rx_par_err;
`endif
      if (tick && rx_state != ST_IDLE) begin
         if (rx_state == ST_START) rx_cnt_nxt = rx_mid_start ? '0 : rx_cnt + 1'b1;
         else                      rx_cnt_nxt = rx_mid ? '0 : rx_cnt + 1'b1;
      end
      case (rx_state)
         ST_IDLE: begin
            if (rx_prev && !rx_s2) begin
               rx_cnt_nxt   = '0;
               rx_state_nxt = ST_START;
            end
         end
         ST_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (rx_mid_start) begin
               rx_idx_nxt   = '0;
               rx_state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_mid) begin
               rx_shift_nxt = {rx_s2, rx_shift[DATA_BITS-1:1]};
               if (rx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                  rx_state_nxt = ST_PARITY;
`else
                  rx_state_nxt = ST_STOP;
`endif
               end else begin
                  rx_idx_nxt = rx_idx + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (rx_mid) begin
`ifdef UART_PARITY_EN
               rx_par_err_nxt = rx_s2 ^ (^rx_shift);
`endif
               rx_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            // Only the first stop bit is checked; RX re-arms right after it.
            if (rx_mid) begin
               rx_push = 1'b1;
`ifdef UART_PARITY_EN
               rx_push_err = !rx_s2 || rx_par_err;
`else
               rx_push_err = !rx_s2;
`endif
               rx_state_nxt = ST_IDLE;
            end
         end
         default: rx_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - self-checking bench for uart_fifo (loopback and driven RX)
module tb_uart_fifo;

   localparam int BIT_CLK = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart_rxd;
   logic       uart_txd;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_full;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_error;
   logic       rx_avail;
   logic       rx_ack;
   logic       rx_overrun;
   logic       loop;
   logic       drv_rxd;
`ifdef UART_PARITY_EN
   logic       drv_par;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   assign uart_rxd = loop ? uart_txd : drv_rxd;

   always #5 clk = ~clk;

   uart_fifo #(
      .FREQ_HZ(100000000), .BAUD(2000000), .OVERSAMPLE(10),
      .DATA_BITS(8), .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(16)
   ) dut (
      .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_error(rx_error), .rx_avail(rx_avail),
      .rx_ack(rx_ack), .rx_overrun(rx_overrun)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      tx_data = b;
      tx_wr   = 1'b1;
      step();
      tx_wr   = 1'b0;
   endtask

   task automatic pop_expect(input logic [7:0] d, input logic e, input string tag);
      int t = 0;
      while (!rx_avail && t < 3000) begin
         step();
         t++;
      end
      check({tag, " avail"}, rx_avail, 1);
      check({tag, " data"}, rx_data, d);
      check({tag, " err"}, rx_error, e);
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
   endtask

   task automatic drain_model(input string tag);
      while (exp_q.size() > 0) begin
         pop_expect(exp_q.pop_front(), 1'b0, tag);
      end
   endtask

   task automatic wait_tx_idle(input int limit);
      int t = 0;
      while (tx_busy && t < limit) begin
         step();
         t++;
      end
      check("tx drain", tx_busy, 0);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      drv_rxd = 1'b0;
      step(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         drv_rxd = b[i];
         step(BIT_CLK);
      end
`ifdef UART_PARITY_EN
      drv_rxd = drv_par;
      step(BIT_CLK);
`endif
      drv_rxd = stop_bit;
      step(BIT_CLK);
      drv_rxd = 1'b1;
      step(BIT_CLK);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] first16[$];
      int t;
      int level;

      reset   = 1'b1;
      tx_data = '0;
      tx_wr   = 1'b0;
      rx_ack  = 1'b0;
      loop    = 1'b1;
      drv_rxd = 1'b1;
`ifdef UART_PARITY_EN
      drv_par = 1'b0;
`endif
      step(3);
      check("rst txd", uart_txd, 1);
      check("rst tx_full", tx_full, 0);
      check("rst tx_busy", tx_busy, 0);
      check("rst rx_avail", rx_avail, 0);
      check("rst rx_error", rx_error, 0);
      check("rst rx_overrun", rx_overrun, 0);
      check("rst rx_data", rx_data, 0);
      reset = 1'b0;
      step(2);

      // Single byte 0x67: line waveform and loopback latency.
      b = 8'h67;
      push(b);
      t = 1;
      check("single busy", tx_busy, 1);
      while (uart_txd && t < 20) begin
         step();
         t++;
      end
      step(BIT_CLK / 2);
      t += BIT_CLK / 2;
      check("single start", uart_txd, 0);
      for (int i = 0; i < 8; i++) begin
         step(BIT_CLK);
         t += BIT_CLK;
         check($sformatf("single bit%0d", i), uart_txd, b[i]);
      end
      step(BIT_CLK);
      t += BIT_CLK;
      check("single stop", uart_txd, 1);
      while (!rx_avail && t < 600) begin
         step();
         t++;
      end
      check("single latency", (t <= 510), 1);
      pop_expect(b, 1'b0, "single");

      // Random bytes with random gaps.
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         push(b);
         exp_q.push_back(b);
         step($urandom_range(0, 3));
      end
      wait_tx_idle(6000);
      step(100);
      drain_model("rand");

      // Burst: a leader frame holds the TX FSM busy so the FIFO only fills.
      b = 8'($urandom);
      push(b);
      exp_q.push_back(b);
      step(10);
      level = 0;
      for (int k = 0; k < 17; k++) begin
         push(8'(k));
         if (level < 16) begin
            level++;
            exp_q.push_back(8'(k));
         end
         check($sformatf("burst full%0d", k), tx_full, (level == 16));
      end
      drain_model("burst");
      step(600);
      check("burst no extra", rx_avail, 0);

      // Overrun: 17 frames received with no rx_ack.
      wait_tx_idle(2000);
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom);
         first16.push_back(b);
         push(b);
      end
      step(20);
      push(8'($urandom));
      wait_tx_idle(12000);
      step(100);
      check("ovr avail", rx_avail, 1);
      check("ovr flag", rx_overrun, 1);
      pop_expect(first16.pop_front(), 1'b0, "ovr first");
      check("ovr cleared", rx_overrun, 0);
      while (first16.size() > 0) begin
         pop_expect(first16.pop_front(), 1'b0, "ovr");
      end
      check("ovr lost", rx_avail, 0);

      // Framing error on a driven line, then a clean frame.
      loop = 1'b0;
      step(10);
`ifdef UART_PARITY_EN
      drv_par = ^8'h55;
`endif
      drive_frame(8'h55, 1'b0);
      pop_expect(8'h55, 1'b1, "frame bad");
      b = 8'($urandom);
`ifdef UART_PARITY_EN
      drv_par = ^b;
`endif
      drive_frame(b, 1'b1);
      pop_expect(b, 1'b0, "frame good");

`ifdef UART_PARITY_EN
      drv_par = 1'b1;
      drive_frame(8'h03, 1'b1);
      pop_expect(8'h03, 1'b1, "parity bad");
      drv_par = 1'b0;
      drive_frame(8'h03, 1'b1);
      pop_expect(8'h03, 1'b0, "parity good");
`endif

      // Reset 20 clk into a TX frame.
      loop = 1'b1;
      step(10);
      push(8'($urandom));
      t = 0;
      while (uart_txd && t < 20) begin
         step();
         t++;
      end
      check("mid start seen", uart_txd, 0);
      step(20);
      reset = 1'b1;
      step();
      check("mid txd", uart_txd, 1);
      check("mid busy", tx_busy, 0);
      check("mid avail", rx_avail, 0);
      reset = 1'b0;
      step(600);
      check("mid no rx", rx_avail, 0);
      check("mid idle txd", uart_txd, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
